// File: rtl/accel_spi_reader_if.sv
// Pin and sample bundle between the ADXL362 reader and its neighbours.
// master: the reader drives the SPI pins and the sample stream.
// slave : the sensor/consumer side (drives miso, observes everything else).
//
// Sample stream: z_valid is a single-cycle strobe with no back-pressure.
// z_data changes only in the cycle z_valid is high and is held otherwise,
// so a consumer must take the sample in the strobe cycle (no ready signal).
interface accel_spi_reader_if;
    logic               sclk;
    logic               mosi;
    logic               miso;
    logic               cs_n;
    logic signed [15:0] z_data;
    logic               z_valid;
    logic               init_done;

    modport master (
        output sclk,
        output mosi,
        output cs_n,
        output z_data,
        output z_valid,
        output init_done,
        input  miso
    );

    modport slave (
        input  sclk,
        input  mosi,
        input  cs_n,
        input  z_data,
        input  z_valid,
        input  init_done,
        output miso
    );
endinterface

// File: rtl/accel_spi_reader.sv
// ADXL362 Z-axis reader: SPI mode-0 master that writes POWER_CTL=measure once
// after a start-up delay, then reads ZDATA_L/ZDATA_H on every sample tick and
// emits the 16-bit sample with a one-cycle z_valid strobe.
module accel_spi_reader #(
    parameter int CLK_DIV        = 50,
    parameter int STARTUP_CYCLES = 500_000,
    parameter int SAMPLE_PERIOD  = 1_000_000
) (
    input  logic               clk,
    input  logic               reset,
    accel_spi_reader_if.master bus,
    output logic [2:0]         dbg_state
);

    localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int START_W = (STARTUP_CYCLES > 1) ? $clog2(STARTUP_CYCLES) : 1;
    localparam int TMR_W   = (SAMPLE_PERIOD > 1) ? $clog2(SAMPLE_PERIOD) : 1;

    localparam logic [DIV_W-1:0]   DIV_LAST   = DIV_W'(CLK_DIV - 1);
    // RD_DONE lasts one cycle less than CLK_DIV; the IDLE cycle that
    // launches the next frame completes the CLK_DIV-cycle cs_n high time.
    localparam logic [DIV_W-1:0]   GAP_LAST   = DIV_W'(CLK_DIV - 2);
    localparam logic [START_W-1:0] START_LAST = START_W'(STARTUP_CYCLES - 1);
    localparam logic [TMR_W-1:0]   TMR_LAST   = TMR_W'(SAMPLE_PERIOD - 1);

    // Half-period index of the trailing low phase: 2*N for N bits.
    localparam logic [6:0] CFG_HALF_LAST = 7'd48;
    localparam logic [6:0] RD_HALF_LAST  = 7'd64;

    // Left-aligned shift words; unused tail bits are zero so MOSI idles low.
    localparam logic [31:0] CFG_WORD = 32'h0A2D_0200;
    localparam logic [31:0] RD_WORD  = 32'h0B12_0000;

    typedef enum logic [2:0] {
        STARTUP  = 3'd0,
        CFG_XFER = 3'd1,
        CFG_GAP  = 3'd2,
        IDLE     = 3'd3,
        RD_XFER  = 3'd4,
        RD_DONE  = 3'd5
    } state_t;

    state_t state;
    state_t state_d;

    logic [START_W-1:0] start_cnt;
    logic [DIV_W-1:0]   div_cnt;
    logic [6:0]         half_cnt;
    logic [31:0]        tx_sr;
    logic [15:0]        rx_sr;
    logic [TMR_W-1:0]   tmr_cnt;
    logic               pending;
    logic               sclk_q;
    logic               cs_n_q;
    logic signed [15:0] z_data_q;
    logic               z_valid_q;
    logic               init_done_q;

    logic in_xfer;
    logic div_last;
    logic half_last;
    logic frame_end;
    logic bit_rise;
    logic bit_fall;
    logic tmr_wrap;
    logic load_cfg;
    logic load_rd;
    logic set_init;

    // Bit-engine decode: where we are inside the current SPI frame.
    always_comb begin
        in_xfer   = 1'b0;
        half_last = 1'b0;
        div_last  = (div_cnt == DIV_LAST);
        if (state == CFG_XFER) begin
            in_xfer   = 1'b1;
            half_last = (half_cnt == CFG_HALF_LAST);
        end else if (state == RD_XFER) begin
            in_xfer   = 1'b1;
            half_last = (half_cnt == RD_HALF_LAST);
        end
        frame_end = in_xfer && div_last && half_last;
        // Even half-periods are low phases: their end is an sclk rising edge
        // unless it is the trailing low phase that closes the frame.
        bit_rise  = in_xfer && div_last && !half_cnt[0] && !half_last;
        bit_fall  = in_xfer && div_last &&  half_cnt[0];
        tmr_wrap  = init_done_q && (tmr_cnt == TMR_LAST);
    end

    // Next-state logic and one-cycle control strobes for the datapath.
    always_comb begin
        state_d  = state;
        load_cfg = 1'b0;
        load_rd  = 1'b0;
        set_init = 1'b0;
        unique case (state)
            STARTUP: begin
                if (start_cnt == START_LAST) begin
                    state_d  = CFG_XFER;
                    load_cfg = 1'b1;
                end
            end
            CFG_XFER: begin
                if (frame_end) state_d = CFG_GAP;
            end
            CFG_GAP: begin
                if (div_last) begin
                    state_d  = IDLE;
                    set_init = 1'b1;
                end
            end
            IDLE: begin
                if (pending) begin
                    state_d = RD_XFER;
                    load_rd = 1'b1;
                end
            end
            RD_XFER: begin
                if (frame_end) state_d = RD_DONE;
            end
            RD_DONE: begin
                if (div_cnt == GAP_LAST) state_d = IDLE;
            end
            default: state_d = STARTUP;
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= STARTUP;
        else        state <= state_d;
    end

    // Power-up delay counter, active only while waiting in STARTUP.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            start_cnt <= '0;
        end else if (state == STARTUP && start_cnt != START_LAST) begin
            start_cnt <= start_cnt + START_W'(1);
        end
    end

    // Clock divider and half-period counter; both restart on every state change.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            div_cnt  <= '0;
            half_cnt <= '0;
        end else if (state_d != state) begin
            div_cnt  <= '0;
            half_cnt <= '0;
        end else if (in_xfer || state == CFG_GAP || state == RD_DONE) begin
            if (div_last) begin
                div_cnt  <= '0;
                half_cnt <= half_cnt + 7'd1;
            end else begin
                div_cnt  <= div_cnt + DIV_W'(1);
            end
        end
    end

    // SPI pins and shift registers: MOSI moves on falling sclk, MISO sampled on rising.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cs_n_q <= 1'b1;
            sclk_q <= 1'b0;
            tx_sr  <= '0;
            rx_sr  <= '0;
        end else if (load_cfg || load_rd) begin
            cs_n_q <= 1'b0;
            sclk_q <= 1'b0;
            tx_sr  <= load_cfg ? CFG_WORD : RD_WORD;
        end else if (frame_end) begin
            cs_n_q <= 1'b1;
            sclk_q <= 1'b0;
        end else if (bit_rise) begin
            sclk_q <= 1'b1;
            // Only the last 16 bits survive: ZDATA_L then ZDATA_H.
            if (state == RD_XFER) rx_sr <= {rx_sr[14:0], bus.miso};
        end else if (bit_fall) begin
            sclk_q <= 1'b0;
            tx_sr  <= {tx_sr[30:0], 1'b0};
        end
    end

    // Sample output: load {H,L} and strobe in the cycle cs_n returns high.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            z_data_q  <= '0;
            z_valid_q <= 1'b0;
        end else if (frame_end && state == RD_XFER) begin
            z_data_q  <= {rx_sr[7:0], rx_sr[15:8]};
            z_valid_q <= 1'b1;
        end else begin
            z_valid_q <= 1'b0;
        end
    end

    // Sample timer and single pending flag; extra ticks while pending are dropped.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            init_done_q <= 1'b0;
            tmr_cnt     <= '0;
            pending     <= 1'b0;
        end else if (set_init) begin
            init_done_q <= 1'b1;
            tmr_cnt     <= '0;
            pending     <= 1'b0;
        end else begin
            if (init_done_q) tmr_cnt <= tmr_wrap ? '0 : tmr_cnt + TMR_W'(1);
            if (load_rd)       pending <= 1'b0;
            else if (tmr_wrap) pending <= 1'b1;
        end
    end

    assign bus.sclk      = sclk_q;
    assign bus.mosi      = tx_sr[31];
    assign bus.cs_n      = cs_n_q;
    assign bus.z_data    = z_data_q;
    assign bus.z_valid   = z_valid_q;
    assign bus.init_done = init_done_q;
    assign dbg_state     = state;

endmodule

// File: tb/tb_accel_spi_reader.sv
// Bench for accel_spi_reader: SPI slave model on the main instance, a second
// instance with a short sample period for back-to-back frames, and a
// scoreboard of expected Z samples consumed on each z_valid strobe.
module tb_accel_spi_reader;

    localparam int CLK_DIV = 2;

    typedef struct packed {
        int          rises;
        logic [31:0] mosi;
        int          low;
        int          st;
        int          en;
    } frame_t;

    // ---------------- clock / reset ----------------
    logic clk   = 1'b0;
    logic reset = 1'b1;
    logic rst_f = 1'b1;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    accel_spi_reader_if bus ();
    accel_spi_reader_if bus_f ();
    logic [2:0] dbg_state;
    logic [2:0] dbg_state_f;

    accel_spi_reader #(.CLK_DIV(CLK_DIV), .STARTUP_CYCLES(10), .SAMPLE_PERIOD(400)) dut (
        .clk       (clk),
        .reset     (reset),
        .bus       (bus),
        .dbg_state (dbg_state)
    );

    accel_spi_reader #(.CLK_DIV(CLK_DIV), .STARTUP_CYCLES(10), .SAMPLE_PERIOD(50)) dut_f (
        .clk       (clk),
        .reset     (rst_f),
        .bus       (bus_f),
        .dbg_state (dbg_state_f)
    );

    assign bus_f.miso = 1'b1;

    // ---------------- scoreboard state ----------------
    int          n_vec = 0;
    int          n_err = 0;
    logic [15:0] exp_q[$];
    frame_t      fr_q[$];
    int          zv_total = 0;
    int          init_rise_cyc = -1000;
    logic [31:0] resp = 32'h0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // ---------------- SPI slave model + monitor (main instance) ----------------
    logic        p_cs_n = 1'b1;
    logic        p_sclk = 1'b0;
    logic        p_zv   = 1'b0;
    logic        p_init = 1'b0;
    logic        in_frame = 1'b0;
    int          rises, low_cnt, bit_i, st_cyc;
    logic [31:0] mosi_cap;
    logic [15:0] e_z;

    always @(negedge clk) begin
        if (!reset) begin
            in_frame = 1'b0;
            bus.miso = 1'b0;
        end else begin
            if (p_cs_n && !bus.cs_n) begin
                in_frame = 1'b1;
                rises    = 0;
                low_cnt  = 0;
                bit_i    = 0;
                mosi_cap = 32'h0;
                st_cyc   = cyc;
                bus.miso = resp[31];
            end
            if (in_frame && !bus.cs_n) begin
                low_cnt++;
                if (!p_sclk && bus.sclk) begin
                    rises++;
                    mosi_cap = {mosi_cap[30:0], bus.mosi};
                end
                if (p_sclk && !bus.sclk) begin
                    bit_i++;
                    bus.miso = (bit_i < 32) ? resp[31-bit_i] : 1'b0;
                end
            end
            if (bus.z_valid) begin
                zv_total++;
                chk("zv_single", {31'h0, p_zv}, 32'h0);
                chk("zv_on_cs_rise", {30'h0, p_cs_n, bus.cs_n}, 32'h1);
                chk("zv_after_init", {31'h0, bus.init_done}, 32'h1);
                if (exp_q.size() == 0) begin
                    chk("zv_unexpected", 32'h1, 32'h0);
                end else begin
                    e_z = exp_q.pop_front();
                    chk("z_data", {16'h0, bus.z_data}, {16'h0, e_z});
                end
            end
            if (in_frame && !p_cs_n && bus.cs_n) begin
                in_frame = 1'b0;
                fr_q.push_back('{rises: rises, mosi: mosi_cap, low: low_cnt, st: st_cyc, en: cyc});
            end
            if (!p_init && bus.init_done) init_rise_cyc = cyc;
        end
        p_cs_n = bus.cs_n;
        p_sclk = bus.sclk;
        p_zv   = bus.z_valid;
        p_init = bus.init_done;
    end

    // ---------------- monitor (short-period instance) ----------------
    logic f_pcs = 1'b1;
    int   f_hi  = 0;
    int   f_zv  = 0;
    int   f_gap_q[$];
    int   f_zv_q[$];

    always @(negedge clk) begin
        if (rst_f) begin
            if (bus_f.z_valid) f_zv++;
            if (f_pcs && !bus_f.cs_n && bus_f.init_done) begin
                f_gap_q.push_back(f_hi);
                f_zv_q.push_back(f_zv);
                f_zv = 0;
            end
            if (bus_f.cs_n) f_hi++;
            else            f_hi = 0;
        end
        f_pcs = bus_f.cs_n;
    end

    // ---------------- driver tasks ----------------
    task automatic release_and_time(input string tag);
        int n;
        n = 0;
        @(negedge clk);
        reset = 1'b1;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (bus.cs_n && n < 100);
        chk(tag, n, 10);
    endtask

    task automatic wait_frame(input string tag, output frame_t f, output bit ok);
        int t;
        t  = 0;
        ok = 1'b0;
        f  = '0;
        while (fr_q.size() == 0 && t < 2000) begin
            @(posedge clk);
            t++;
        end
        if (fr_q.size() == 0) begin
            chk({tag, "_timeout"}, 32'h1, 32'h0);
        end else begin
            f  = fr_q.pop_front();
            ok = 1'b1;
        end
    endtask

    // ---------------- main sequence ----------------
    initial begin
        frame_t f;
        frame_t f_prev;
        bit     ok;
        int     n;
        int     t;
        logic   ps;
        int     zv_before;

        #2;
        reset = 1'b0;
        rst_f = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        chk("rst_sclk", {31'h0, bus.sclk}, 32'h0);
        chk("rst_mosi", {31'h0, bus.mosi}, 32'h0);
        chk("rst_cs_n", {31'h0, bus.cs_n}, 32'h1);
        chk("rst_z_data", {16'h0, bus.z_data}, 32'h0);
        chk("rst_z_valid", {31'h0, bus.z_valid}, 32'h0);
        chk("rst_init_done", {31'h0, bus.init_done}, 32'h0);
        chk("rst_state", {29'h0, dbg_state}, 32'h0);

        @(negedge clk);
        rst_f = 1'b1;
        release_and_time("startup_len");

        // Configuration write
        wait_frame("cfg", f, ok);
        chk("cfg_rises", f.rises, 24);
        chk("cfg_mosi", f.mosi, 32'h000A_2D02);
        chk("cfg_cs_low", f.low, 98);
        repeat (CLK_DIV + 3) @(posedge clk);
        #1;
        chk("init_done", {31'h0, bus.init_done}, 32'h1);
        chk("init_delay", init_rise_cyc - f.en, CLK_DIV);

        // Positive read
        resp = {16'h0, 8'h34, 8'h12};
        exp_q.push_back(16'h1234);
        wait_frame("rd1", f, ok);
        chk("rd1_rises", f.rises, 32);
        chk("rd1_mosi", f.mosi, 32'h0B12_0000);
        chk("rd1_cs_low", f.low, 130);
        f_prev = f;

        // Negative read, then hold check until the next frame
        resp = {16'h0, 8'hF0, 8'hFF};
        exp_q.push_back(16'hFFF0);
        wait_frame("rd2", f, ok);
        chk("rd2_mosi", f.mosi, 32'h0B12_0000);
        chk("rd_spacing", f.st - f_prev.st, 400);
        resp = {16'h0, 8'h5A, 8'h01};
        exp_q.push_back(16'h015A);
        for (int i = 0; i < 6; i++) begin
            repeat (40) @(posedge clk);
            #1;
            chk("z_hold", {16'h0, bus.z_data}, 32'h0000_FFF0);
        end
        wait_frame("rd3", f, ok);
        chk("rd3_rises", f.rises, 32);
        repeat (2) @(posedge clk);
        #1;
        chk("z_after_rd3", {16'h0, bus.z_data}, 32'h0000_015A);

        // Reset in the middle of a read
        resp = {16'h0, 8'hAA, 8'h55};
        n  = 0;
        t  = 0;
        ps = bus.sclk;
        while (n < 10 && t < 1000) begin
            @(posedge clk);
            #1;
            t++;
            if (bus.sclk && !ps) n++;
            ps = bus.sclk;
        end
        chk("mid_rd_rises", n, 10);
        zv_before = zv_total;
        reset = 1'b0;
        #1;
        chk("mid_rst_cs_n", {31'h0, bus.cs_n}, 32'h1);
        chk("mid_rst_sclk", {31'h0, bus.sclk}, 32'h0);
        repeat (4) @(posedge clk);
        #1;
        chk("mid_rst_zv", {31'h0, bus.z_valid}, 32'h0);
        chk("mid_rst_init", {31'h0, bus.init_done}, 32'h0);
        release_and_time("restart_len");
        chk("restart_init", {31'h0, bus.init_done}, 32'h0);
        wait_frame("cfg2", f, ok);
        chk("cfg2_rises", f.rises, 24);
        chk("cfg2_mosi", f.mosi, 32'h000A_2D02);
        chk("mid_rst_no_zv", zv_total, zv_before);

        // Back-to-back frames on the short-period instance
        t = 0;
        while (f_gap_q.size() < 7 && t < 5000) begin
            @(posedge clk);
            t++;
        end
        chk("fast_frames", {31'h0, f_gap_q.size() >= 7}, 32'h1);
        for (int i = 2; i < 7; i++) begin
            if (i < f_gap_q.size()) begin
                chk("fast_gap", f_gap_q[i], CLK_DIV);
                chk("fast_zv_per_frame", f_zv_q[i], 1);
            end
        end
        chk("fast_z", {16'h0, bus_f.z_data}, 32'h0000_FFFF);

        chk("zv_total", zv_total, 3);
        chk("exp_q_empty", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
